// File: rtl/btn_pkg.sv
// Shared types and default tick constants for the push-button gesture classifier.
// The defaults assume the 32 kHz watch clock.
package btn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_WAIT2,
      ST_PRESSED2,
      ST_HELD
   } state_t;

   localparam int DEF_CNT_W        = 16;
   localparam int DEF_LONG_TICKS   = 32768;  // 1.0 s
   localparam int DEF_DOUBLE_GAP   = 9830;   // ~300 ms
   localparam int DEF_REPEAT_TICKS = 6554;   // ~200 ms
   localparam bit DEF_REPEAT_EN    = 1'b1;

endpackage

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release pulses into short, double and long presses,
// with auto-repeat while the button stays held after a long press.
module button_press_classifier
   import btn_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DOUBLE_GAP   = DEF_DOUBLE_GAP,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter bit REPEAT_EN    = DEF_REPEAT_EN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_down,
   input  logic btn_up,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic busy
);

   if (LONG_TICKS < 2 || LONG_TICKS >= (1 << CNT_W)) begin : g_bad_long
      $error("LONG_TICKS must be >= 2 and fit in CNT_W bits");
   end
   if (DOUBLE_GAP < 2 || DOUBLE_GAP >= (1 << CNT_W)) begin : g_bad_gap
      $error("DOUBLE_GAP must be >= 2 and fit in CNT_W bits");
   end
   if (REPEAT_TICKS < 2 || REPEAT_TICKS >= (1 << CNT_W)) begin : g_bad_rep
      $error("REPEAT_TICKS must be >= 2 and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP - 1);
   localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_TICKS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             busy_q, busy_d;
   logic             down_ev, up_ev, restart;

   // Simultaneous down and up cancel each other out.
   assign down_ev = btn_down & ~btn_up;
   assign up_ev   = btn_up & ~btn_down;

   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      restart  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (down_ev) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (up_ev) begin
               state_d = ST_WAIT2;
            end else if (cnt_q == LONG_TC) begin
               long_d  = 1'b1;
               state_d = ST_HELD;
            end
         end
         ST_WAIT2: begin
            if (down_ev) begin
               state_d = ST_PRESSED2;
            end else if (cnt_q == GAP_TC) begin
               short_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_PRESSED2: begin
            // The first tap was short; holding the second one also makes it long.
            if (up_ev) begin
               double_d = 1'b1;
               state_d  = ST_IDLE;
            end else if (cnt_q == LONG_TC) begin
               short_d = 1'b1;
               long_d  = 1'b1;
               state_d = ST_HELD;
            end
         end
         ST_HELD: begin
            if (up_ev) begin
               state_d = ST_IDLE;
            end else if (REPEAT_EN && cnt_q == REP_TC) begin
               repeat_d = 1'b1;
               restart  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter restarts on any state change and saturates instead of wrapping.
      if (state_d != state_q || restart) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         busy_q   <= busy_d;
      end
   end

   assign short_press  = short_q;
   assign double_press = double_q;
   assign long_press   = long_q;
   assign repeat_press = repeat_q;
   assign busy         = busy_q;

endmodule
